// File: rtl/pong_pkg.sv
// Shared constants and state type for the pong LED-matrix display path.
package pong_pkg;

  localparam int SCREEN_W = 16;
  localparam int SCREEN_H = 16;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_DWELL
  } drv_state_t;

endpackage

// File: rtl/matrix_driver_if.sv
// Ball/paddle position bus: the game logic is the master, the matrix driver consumes it.
interface matrix_driver_if;

  logic [3:0] ball_x;
  logic [3:0] ball_y;
  logic [3:0] paddle_l;
  logic [3:0] paddle_r;

  modport master (output ball_x, output ball_y, output paddle_l, output paddle_r);
  modport slave  (input  ball_x, input  ball_y, input  paddle_l, input  paddle_r);

endinterface

// File: rtl/matrix_driver_row_pattern.sv
// Combinational column pattern for one matrix row: ball dot plus left/right paddle segments.
module row_pattern
  import pong_pkg::*;
#(
  parameter int PADDLE_LEN = 3
) (
  input  logic [3:0]          bx,
  input  logic [3:0]          by,
  input  logic [3:0]          pl,
  input  logic [3:0]          pr,
  input  logic [3:0]          cur_row,
  input  logic                ball_en,
  output logic [SCREEN_W-1:0] pattern
);

  logic [4:0] row5;
  logic [4:0] pl_end;
  logic [4:0] pr_end;
  logic       left_on;
  logic       right_on;

  // Paddle extents are computed 5 bits wide so a paddle near the bottom clips instead of wrapping to row 0.
  assign row5     = {1'b0, cur_row};
  assign pl_end   = {1'b0, pl} + 5'(PADDLE_LEN - 1);
  assign pr_end   = {1'b0, pr} + 5'(PADDLE_LEN - 1);
  assign left_on  = (row5 >= {1'b0, pl}) && (row5 <= pl_end);
  assign right_on = (row5 >= {1'b0, pr}) && (row5 <= pr_end);

  always_comb begin
    pattern = '0;
    if (ball_en && (by == cur_row)) pattern[bx] = 1'b1;
    if (left_on)  pattern[0]          = 1'b1;
    if (right_on) pattern[SCREEN_W-1] = 1'b1;
  end

endmodule

// File: rtl/matrix_driver.sv
// Row-multiplexed 16x16 LED matrix driver for the pong ball and paddles.
// Optional MATRIX_DRIVER_BLINK_EN: ball blinks with a frame counter bit.
module matrix_driver
  import pong_pkg::*;
#(
  parameter int DWELL      = 64,
  parameter int PADDLE_LEN = 3,
  parameter int BLINK_BIT  = 3
) (
  input  logic            clk,
  input  logic            reset,
  matrix_driver_if.slave  pos,
  output logic [3:0]      row,
  output logic            col_data,
  output logic            col_sclk,
  output logic            col_latch,
  output logic            blank,
  output logic            frame_done
);

  localparam int DW_W = (DWELL > 2) ? $clog2(DWELL) : 1;

  drv_state_t state_q;
  drv_state_t state_d;

  logic [3:0]          load_row;
  logic [3:0]          f_bx;
  logic [3:0]          f_by;
  logic [3:0]          f_pl;
  logic [3:0]          f_pr;
  logic [SCREEN_W-1:0] sr;
  logic [4:0]          bit_cnt;
  logic [DW_W-1:0]     dwell_cnt;
  logic                latch_ph;

  logic load_en;
  logic shift_en;
  logic latch_on;
  logic latch_off;
  logic dwell_en;

  logic                snap;
  logic                ball_en;
  logic [3:0]          src_bx;
  logic [3:0]          src_by;
  logic [3:0]          src_pl;
  logic [3:0]          src_pr;
  logic [SCREEN_W-1:0] pattern;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == 5'd31) state_d = ST_LATCH;
      ST_LATCH: if (latch_ph) state_d = ST_DWELL;
      ST_DWELL: if (dwell_cnt == '0) state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    load_en   = (state_q == ST_LOAD);
    shift_en  = (state_q == ST_SHIFT);
    latch_on  = (state_q == ST_LATCH) && !latch_ph;
    latch_off = (state_q == ST_LATCH) &&  latch_ph;
    dwell_en  = (state_q == ST_DWELL);
  end

  // Row 0 renders straight from the live inputs in the same cycle they are snapshotted.
  assign snap   = (load_row == 4'd0);
  assign src_bx = snap ? pos.ball_x   : f_bx;
  assign src_by = snap ? pos.ball_y   : f_by;
  assign src_pl = snap ? pos.paddle_l : f_pl;
  assign src_pr = snap ? pos.paddle_r : f_pr;

`ifdef MATRIX_DRIVER_BLINK_EN
  logic [3:0] frame_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          frame_cnt <= 4'd0;
    else if (frame_done) frame_cnt <= frame_cnt + 4'd1;
  end

  assign ball_en = ~frame_cnt[BLINK_BIT];
`else
  assign ball_en = 1'b1;
`endif

  row_pattern #(
    .PADDLE_LEN (PADDLE_LEN)
  ) u_row_pattern (
    .bx      (src_bx),
    .by      (src_by),
    .pl      (src_pl),
    .pr      (src_pr),
    .cur_row (load_row),
    .ball_en (ball_en),
    .pattern (pattern)
  );

  // Datapath: serial shift on a two-cycle sclk, then blank/latch/unblank around the row switch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row        <= 4'd0;
      col_data   <= 1'b0;
      col_sclk   <= 1'b0;
      col_latch  <= 1'b0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
      load_row   <= 4'd0;
      f_bx       <= 4'd0;
      f_by       <= 4'd0;
      f_pl       <= 4'd0;
      f_pr       <= 4'd0;
      sr         <= '0;
      bit_cnt    <= 5'd0;
      dwell_cnt  <= '0;
      latch_ph   <= 1'b0;
    end else begin
      if (load_en) begin
        if (snap) begin
          f_bx <= pos.ball_x;
          f_by <= pos.ball_y;
          f_pl <= pos.paddle_l;
          f_pr <= pos.paddle_r;
        end
        sr      <= pattern;
        bit_cnt <= 5'd0;
      end

      if (shift_en) begin
        bit_cnt <= bit_cnt + 5'd1;
        if (!bit_cnt[0]) begin
          col_sclk <= 1'b0;
          col_data <= sr[SCREEN_W-1];
        end else begin
          col_sclk <= 1'b1;
          sr       <= {sr[SCREEN_W-2:0], 1'b0};
        end
      end else begin
        col_sclk <= 1'b0;
        col_data <= 1'b0;
      end

      col_latch  <= latch_on;
      frame_done <= latch_off && (load_row == 4'd15);

      if (latch_on) begin
        blank    <= 1'b1;
        row      <= load_row;
        latch_ph <= 1'b1;
      end

      if (latch_off) begin
        blank     <= 1'b0;
        load_row  <= load_row + 4'd1;
        dwell_cnt <= DW_W'(DWELL - 1);
        latch_ph  <= 1'b0;
      end

      if (dwell_en) dwell_cnt <= dwell_cnt - 1'b1;
    end
  end

endmodule
